// File: rtl/mem_tg_cfg_seq.sv
// Hardware sequencer for one memory traffic generator: writes the TG configuration,
// starts the test, polls for completion and collects pass/fail/failure-count results.
module mem_tg_cfg_seq #(
    parameter int unsigned POLL_INTERVAL  = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1 << 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] cfg_loop_count,
    input  logic [31:0] cfg_write_count,
    input  logic [31:0] cfg_read_count,
    input  logic [31:0] cfg_burst_length,
    input  logic [63:0] cfg_wr_start_addr,
    input  logic [63:0] cfg_rd_start_addr,
    input  logic [1:0]  cfg_addr_mode_wr,
    input  logic [1:0]  cfg_addr_mode_rd,
    output logic [11:0] tg_address,
    output logic        tg_write,
    output logic        tg_read,
    output logic [31:0] tg_writedata,
    input  logic [31:0] tg_readdata,
    input  logic        tg_readdatavalid,
    input  logic        tg_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [63:0] fail_count
);

    localparam int unsigned PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG_WR, S_START_WR, S_POLL_WAIT, S_POLL_RD, S_RES_RD, S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic           wr_q, wr_d, rd_q, rd_d, pend_q, pend_d;
    logic [11:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [PW-1:0]  poll_q, poll_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic           busy_q, busy_d, done_q, done_d;
    logic           pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
    logic [63:0]    fc_q, fc_d;
    logic           res_pass_q, res_pass_d, res_fail_q, res_fail_d;
    logic [31:0]    res_lo_q, res_lo_d;
    // Loop count is never latched: it is consumed as the first write on the accept edge.
    logic [31:0]    wcnt_q, wcnt_d, rcnt_q, rcnt_d, burst_q, burst_d;
    logic [63:0]    wraddr_q, wraddr_d, rdaddr_q, rdaddr_d;
    logic [1:0]     mwr_q, mwr_d, mrd_q, mrd_d;

    logic           acc, rvalid, to_hit, fin, fin_to;
    logic [3:0]     nidx;
    logic [31:0]    cfg_wdata;

    function automatic logic [11:0] cfg_addr(input logic [3:0] i);
        case (i)
            4'd0:    return 12'h008;
            4'd1:    return 12'h00C;
            4'd2:    return 12'h010;
            4'd3:    return 12'h01C;
            4'd4:    return 12'h040;
            4'd5:    return 12'h044;
            4'd6:    return 12'h048;
            4'd7:    return 12'h078;
            4'd8:    return 12'h07C;
            default: return 12'h080;
        endcase
    endfunction

    function automatic logic [11:0] res_addr(input logic [1:0] i);
        case (i)
            2'd0:    return 12'h088;
            2'd1:    return 12'h08C;
            2'd2:    return 12'h090;
            default: return 12'h094;
        endcase
    endfunction

    assign acc    = (wr_q | rd_q) & ~tg_waitrequest;
    assign rvalid = pend_q & tg_readdatavalid;
    assign to_hit = (to_cnt_q == TW'(TIMEOUT_CYCLES));
    assign nidx   = idx_q + 4'd1;

    always_comb begin
        cfg_wdata = '0;
        case (nidx)
            4'd1:    cfg_wdata = wcnt_q;
            4'd2:    cfg_wdata = rcnt_q;
            4'd3:    cfg_wdata = burst_q;
            4'd4:    cfg_wdata = wraddr_q[31:0];
            4'd5:    cfg_wdata = wraddr_q[63:32];
            4'd6:    cfg_wdata = {30'd0, mwr_q};
            4'd7:    cfg_wdata = rdaddr_q[31:0];
            4'd8:    cfg_wdata = rdaddr_q[63:32];
            4'd9:    cfg_wdata = {30'd0, mrd_q};
            default: cfg_wdata = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        pend_d     = pend_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        poll_d     = poll_q;
        to_cnt_d   = to_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        fail_d     = fail_q;
        timeout_d  = timeout_q;
        fc_d       = fc_q;
        res_pass_d = res_pass_q;
        res_fail_d = res_fail_q;
        res_lo_d   = res_lo_q;
        wcnt_d     = wcnt_q;
        rcnt_d     = rcnt_q;
        burst_d    = burst_q;
        wraddr_d   = wraddr_q;
        rdaddr_d   = rdaddr_q;
        mwr_d      = mwr_q;
        mrd_d      = mrd_q;
        fin        = 1'b0;
        fin_to     = 1'b0;

        if ((state_q == S_POLL_WAIT || state_q == S_POLL_RD) && !to_hit) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    wcnt_d    = cfg_write_count;
                    rcnt_d    = cfg_read_count;
                    burst_d   = cfg_burst_length;
                    wraddr_d  = cfg_wr_start_addr;
                    rdaddr_d  = cfg_rd_start_addr;
                    mwr_d     = cfg_addr_mode_wr;
                    mrd_d     = cfg_addr_mode_rd;
                    state_d   = S_CFG_WR;
                    idx_d     = '0;
                    wr_d      = 1'b1;
                    addr_d    = 12'h008;
                    wdata_d   = cfg_loop_count;
                    busy_d    = 1'b1;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                    fc_d      = '0;
                end
            end
            S_CFG_WR: begin
                if (acc) begin
                    if (idx_q == 4'd9) begin
                        state_d = S_START_WR;
                        addr_d  = 12'h004;
                        wdata_d = 32'd1;
                    end else begin
                        idx_d   = nidx;
                        addr_d  = cfg_addr(nidx);
                        wdata_d = cfg_wdata;
                    end
                end
            end
            S_START_WR: begin
                if (acc) begin
                    wr_d     = 1'b0;
                    to_cnt_d = '0;
                    poll_d   = '0;
                    state_d  = S_POLL_WAIT;
                end
            end
            S_POLL_WAIT: begin
                if (to_hit) begin
                    fin    = 1'b1;
                    fin_to = 1'b1;
                end else if (poll_q == PW'(POLL_INTERVAL - 1)) begin
                    state_d = S_POLL_RD;
                    rd_d    = 1'b1;
                    addr_d  = 12'h0A8;
                end else begin
                    poll_d = poll_q + PW'(1);
                end
            end
            S_POLL_RD: begin
                // A timeout during a poll still waits out that read; its completion bit is discarded.
                if (acc) begin
                    rd_d   = 1'b0;
                    pend_d = 1'b1;
                end else if (rvalid) begin
                    pend_d = 1'b0;
                    if (to_hit) begin
                        fin    = 1'b1;
                        fin_to = 1'b1;
                    end else if (tg_readdata[0]) begin
                        state_d = S_RES_RD;
                        idx_d   = '0;
                        rd_d    = 1'b1;
                        addr_d  = 12'h088;
                    end else begin
                        state_d = S_POLL_WAIT;
                        poll_d  = '0;
                    end
                end
            end
            S_RES_RD: begin
                if (acc) begin
                    rd_d   = 1'b0;
                    pend_d = 1'b1;
                end else if (rvalid) begin
                    pend_d = 1'b0;
                    case (idx_q[1:0])
                        2'd0:    res_pass_d = tg_readdata[0];
                        2'd1:    res_fail_d = tg_readdata[0];
                        2'd2:    res_lo_d   = tg_readdata;
                        default: fin        = 1'b1;
                    endcase
                    if (idx_q[1:0] != 2'd3) begin
                        idx_d  = nidx;
                        rd_d   = 1'b1;
                        addr_d = res_addr(idx_q[1:0] + 2'd1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fin) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            if (fin_to) begin
                timeout_d = 1'b1;
                pass_d    = 1'b0;
                fail_d    = 1'b0;
                fc_d      = '0;
            end else begin
                pass_d = res_pass_q;
                fail_d = res_fail_q;
                fc_d   = {tg_readdata, res_lo_q};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            pend_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            poll_q     <= '0;
            to_cnt_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            timeout_q  <= 1'b0;
            fc_q       <= '0;
            res_pass_q <= 1'b0;
            res_fail_q <= 1'b0;
            res_lo_q   <= '0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            burst_q    <= '0;
            wraddr_q   <= '0;
            rdaddr_q   <= '0;
            mwr_q      <= '0;
            mrd_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            pend_q     <= pend_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            poll_q     <= poll_d;
            to_cnt_q   <= to_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            timeout_q  <= timeout_d;
            fc_q       <= fc_d;
            res_pass_q <= res_pass_d;
            res_fail_q <= res_fail_d;
            res_lo_q   <= res_lo_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            burst_q    <= burst_d;
            wraddr_q   <= wraddr_d;
            rdaddr_q   <= rdaddr_d;
            mwr_q      <= mwr_d;
            mrd_q      <= mrd_d;
        end
    end

    assign tg_address   = addr_q;
    assign tg_write     = wr_q;
    assign tg_read      = rd_q;
    assign tg_writedata = wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign timeout      = timeout_q;
    assign fail_count   = fc_q;

endmodule

// File: tb/tb_mem_tg_cfg_seq.sv
// Scoreboard bench for mem_tg_cfg_seq: a TG CSR model answers reads, a monitor
// checks every accepted command and every done pulse against queued expectations.
module tb_mem_tg_cfg_seq;

    localparam int unsigned PI = 8;
    localparam int unsigned TO = 200;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [31:0] cfg_loop_count, cfg_write_count, cfg_read_count, cfg_burst_length;
    logic [63:0] cfg_wr_start_addr, cfg_rd_start_addr;
    logic [1:0]  cfg_addr_mode_wr, cfg_addr_mode_rd;
    logic [11:0] tg_address;
    logic        tg_write, tg_read;
    logic [31:0] tg_writedata, tg_readdata;
    logic        tg_readdatavalid, tg_waitrequest;
    logic        busy, done, pass, fail, timeout;
    logic [63:0] fail_count;

    mem_tg_cfg_seq #(.POLL_INTERVAL(PI), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_loop_count(cfg_loop_count), .cfg_write_count(cfg_write_count),
        .cfg_read_count(cfg_read_count), .cfg_burst_length(cfg_burst_length),
        .cfg_wr_start_addr(cfg_wr_start_addr), .cfg_rd_start_addr(cfg_rd_start_addr),
        .cfg_addr_mode_wr(cfg_addr_mode_wr), .cfg_addr_mode_rd(cfg_addr_mode_rd),
        .tg_address(tg_address), .tg_write(tg_write), .tg_read(tg_read),
        .tg_writedata(tg_writedata), .tg_readdata(tg_readdata),
        .tg_readdatavalid(tg_readdatavalid), .tg_waitrequest(tg_waitrequest),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic wr; logic [11:0] addr; logic [31:0] data; } cmd_t;
    typedef struct packed { logic p; logic f; logic t; logic [63:0] fc; } res_t;

    cmd_t exp_cmd[$];
    res_t exp_res[$];

    int unsigned vectors = 0, miscompares = 0;
    int          cyc = 0, last_poll = -1, first_wr_cyc = 0, last_wr_cyc = 0;
    int unsigned done_cnt = 0;
    bit          poll_free = 0, prev_done = 0;

    // TG model knobs
    int unsigned stall_max = 0, lat_min = 1, lat_max = 1, complete_after = 0, poll_idx = 0;
    logic [31:0] m_pass = '0, m_fail = '0, m_fcl = '0, m_fch = '0, m_rdata = '0;
    bit          m_pend = 0, held = 0;
    int unsigned m_lat = 0, stall_left = 0;
    logic [45:0] saved = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_cfg(input logic [31:0] lc, input logic [31:0] wc, input logic [31:0] rc,
                            input logic [31:0] bl, input logic [63:0] wa, input logic [63:0] ra,
                            input logic [1:0] mw, input logic [1:0] mr);
        exp_cmd.push_back({1'b1, 12'h008, lc});
        exp_cmd.push_back({1'b1, 12'h00C, wc});
        exp_cmd.push_back({1'b1, 12'h010, rc});
        exp_cmd.push_back({1'b1, 12'h01C, bl});
        exp_cmd.push_back({1'b1, 12'h040, wa[31:0]});
        exp_cmd.push_back({1'b1, 12'h044, wa[63:32]});
        exp_cmd.push_back({1'b1, 12'h048, {30'd0, mw}});
        exp_cmd.push_back({1'b1, 12'h078, ra[31:0]});
        exp_cmd.push_back({1'b1, 12'h07C, ra[63:32]});
        exp_cmd.push_back({1'b1, 12'h080, {30'd0, mr}});
        exp_cmd.push_back({1'b1, 12'h004, 32'd1});
    endtask

    task automatic push_reads(input int unsigned polls);
        for (int unsigned i = 0; i < polls; i++) exp_cmd.push_back({1'b0, 12'h0A8, 32'd0});
        exp_cmd.push_back({1'b0, 12'h088, 32'd0});
        exp_cmd.push_back({1'b0, 12'h08C, 32'd0});
        exp_cmd.push_back({1'b0, 12'h090, 32'd0});
        exp_cmd.push_back({1'b0, 12'h094, 32'd0});
    endtask

    task automatic drive_start(input logic [31:0] lc, input logic [31:0] wc, input logic [31:0] rc,
                               input logic [31:0] bl, input logic [63:0] wa, input logic [63:0] ra,
                               input logic [1:0] mw, input logic [1:0] mr);
        @(negedge clk);
        cfg_loop_count = lc; cfg_write_count = wc; cfg_read_count = rc; cfg_burst_length = bl;
        cfg_wr_start_addr = wa; cfg_rd_start_addr = ra; cfg_addr_mode_wr = mw; cfg_addr_mode_rd = mr;
        start = 1'b1;
        @(posedge clk); #1;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("write_after_start", 64'(tg_write), 64'd1);
        @(negedge clk);
        start = 1'b0;
        cfg_loop_count = ~lc; cfg_write_count = ~wc; cfg_read_count = ~rc; cfg_burst_length = ~bl;
        cfg_wr_start_addr = ~wa; cfg_rd_start_addr = ~ra; cfg_addr_mode_wr = ~mw; cfg_addr_mode_rd = ~mr;
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned n0 = done_cnt;
        for (int unsigned i = 0; i < budget && done_cnt == n0; i++) @(negedge clk);
        chk("done_within_budget", 64'(done_cnt != n0), 64'd1);
        chk("cmd_queue_drained", 64'(exp_cmd.size()), 64'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_address"}, 64'(tg_address), 64'd0);
        chk({tag, "_write"}, 64'(tg_write), 64'd0);
        chk({tag, "_read"}, 64'(tg_read), 64'd0);
        chk({tag, "_wdata"}, 64'(tg_writedata), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_fail"}, 64'(fail), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
        chk({tag, "_fail_count"}, fail_count, 64'd0);
    endtask

    // TG CSR model: waitrequest stalls, read latency, register contents
    initial begin
        tg_waitrequest = 1'b0; tg_readdatavalid = 1'b0; tg_readdata = '0;
        forever begin
            @(negedge clk);
            tg_readdatavalid = 1'b0;
            if (m_pend) begin
                m_lat--;
                if (m_lat == 0) begin
                    m_pend = 0;
                    tg_readdatavalid = 1'b1;
                    tg_readdata = m_rdata;
                end
            end
            if (tg_write || tg_read) begin
                if (held) chk("cmd_stable_in_stall", 64'({tg_write, tg_read, tg_address, tg_writedata}), 64'(saved));
                else stall_left = $urandom_range(stall_max, 0);
                tg_waitrequest = (stall_left > 0);
                if (stall_left > 0) stall_left--;
                held = tg_waitrequest;
                saved = {tg_write, tg_read, tg_address, tg_writedata};
                if (!tg_waitrequest) begin
                    chk("one_outstanding", 64'(m_pend), 64'd0);
                    if (tg_read) begin
                        m_pend = 1;
                        m_lat = $urandom_range(lat_max, lat_min);
                        case (tg_address)
                            12'h0A8: begin m_rdata = (poll_idx >= complete_after) ? 32'd1 : 32'd0; poll_idx++; end
                            12'h088: m_rdata = m_pass;
                            12'h08C: m_rdata = m_fail;
                            12'h090: m_rdata = m_fcl;
                            12'h094: m_rdata = m_fch;
                            default: m_rdata = 32'hDEAD_BEEF;
                        endcase
                    end
                end
            end else begin
                held = 0;
                tg_waitrequest = (stall_max > 0) ? 1'($urandom_range(1, 0)) : 1'b0;
            end
        end
    end

    // Monitor: pops expectations on each accepted command and on each done pulse
    initial begin
        cmd_t e;
        res_t r;
        forever begin
            @(negedge clk); #2;
            if (rst_n) begin
                if ((tg_write || tg_read) && !tg_waitrequest) begin
                    if (!poll_free || exp_cmd.size() != 0) begin
                        chk("cmd_expected", 64'(exp_cmd.size() != 0), 64'd1);
                        if (exp_cmd.size() != 0) begin
                            e = exp_cmd.pop_front();
                            chk("cmd_kind", 64'(tg_write), 64'(e.wr));
                            chk("cmd_addr", 64'(tg_address), 64'(e.addr));
                            if (e.wr) chk("cmd_wdata", 64'(tg_writedata), 64'(e.data));
                        end
                        if (tg_read && tg_address == 12'h0A8) begin
                            if (last_poll >= 0) chk("poll_spacing_ok", 64'((cyc - last_poll) >= int'(PI)), 64'd1);
                            last_poll = cyc;
                        end
                    end else begin
                        chk("only_polls_after_cfg", 64'({tg_read, tg_address}), 64'({1'b1, 12'h0A8}));
                    end
                    if (tg_write && tg_address == 12'h008) first_wr_cyc = cyc;
                    if (tg_write && tg_address == 12'h004) last_wr_cyc = cyc;
                end
                if (done) begin
                    chk("done_single_cycle", 64'(prev_done), 64'd0);
                    chk("result_expected", 64'(exp_res.size() != 0), 64'd1);
                    if (exp_res.size() != 0) begin
                        r = exp_res.pop_front();
                        chk("res_pass", 64'(pass), 64'(r.p));
                        chk("res_fail", 64'(fail), 64'(r.f));
                        chk("res_timeout", 64'(timeout), 64'(r.t));
                        chk("res_fail_count", fail_count, r.fc);
                        chk("busy_low_at_done", 64'(busy), 64'd0);
                    end
                    done_cnt++;
                end
                prev_done = done;
            end
        end
    end

    initial begin
        int unsigned n0;
        rst_n = 1'b0; start = 1'b0;
        cfg_loop_count = '0; cfg_write_count = '0; cfg_read_count = '0; cfg_burst_length = '0;
        cfg_wr_start_addr = '0; cfg_rd_start_addr = '0; cfg_addr_mode_wr = '0; cfg_addr_mode_rd = '0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Config order and pass path: two incomplete polls, then complete
        stall_max = 0; lat_min = 1; lat_max = 3; complete_after = 2; poll_idx = 0;
        m_pass = 32'd1; m_fail = 32'd0; m_fcl = 32'd0; m_fch = 32'd0;
        push_cfg(32'd1, 32'h10, 32'h10, 32'd4, 64'h1_0000_0040, 64'h40, 2'd2, 2'd2);
        push_reads(3);
        exp_res.push_back({1'b1, 1'b0, 1'b0, 64'd0});
        last_poll = -1;
        drive_start(32'd1, 32'd16, 32'd16, 32'd4, 64'h1_0000_0040, 64'h40, 2'd2, 2'd2);
        wait_done(2000);
        chk("cfg_writes_consecutive", 64'(last_wr_cyc - first_wr_cyc), 64'd10);

        // Fail path with a nonzero 64-bit failure count
        complete_after = 0; poll_idx = 0;
        m_pass = 32'd0; m_fail = 32'd1; m_fcl = 32'd5; m_fch = 32'd2;
        push_cfg(32'd3, 32'h100, 32'h80, 32'd8, 64'h0000_0002_0000_1000, 64'hFFFF_0000_0000_2000, 2'd1, 2'd3);
        push_reads(1);
        exp_res.push_back({1'b0, 1'b1, 1'b0, 64'h0000_0002_0000_0005});
        last_poll = -1;
        drive_start(32'd3, 32'h100, 32'h80, 32'd8, 64'h0000_0002_0000_1000, 64'hFFFF_0000_0000_2000, 2'd1, 2'd3);
        wait_done(2000);

        // Same pass run under random stalls and read latency
        stall_max = 5; lat_min = 1; lat_max = 8; complete_after = 2; poll_idx = 0;
        m_pass = 32'd1; m_fail = 32'd0; m_fcl = 32'd0; m_fch = 32'd0;
        push_cfg(32'd1, 32'h10, 32'h10, 32'd4, 64'h1_0000_0040, 64'h40, 2'd2, 2'd2);
        push_reads(3);
        exp_res.push_back({1'b1, 1'b0, 1'b0, 64'd0});
        last_poll = -1;
        drive_start(32'd1, 32'd16, 32'd16, 32'd4, 64'h1_0000_0040, 64'h40, 2'd2, 2'd2);
        wait_done(4000);

        // Timeout: completion never reported, only polls may follow the config writes
        stall_max = 0; lat_min = 1; lat_max = 3; complete_after = 32'hFFFF_FFFF; poll_idx = 0;
        m_pass = 32'd1; m_fail = 32'd1; m_fcl = 32'd7; m_fch = 32'd7;
        push_cfg(32'd2, 32'd4, 32'd4, 32'd1, 64'h80, 64'h80, 2'd0, 2'd1);
        exp_res.push_back({1'b0, 1'b0, 1'b1, 64'd0});
        poll_free = 1;
        drive_start(32'd2, 32'd4, 32'd4, 32'd1, 64'h80, 64'h80, 2'd0, 2'd1);
        wait_done(1000);
        poll_free = 0;

        // Start while busy is ignored; reset during an outstanding poll read
        lat_min = 20; lat_max = 20; complete_after = 0; poll_idx = 0;
        push_cfg(32'd9, 32'd8, 32'd7, 32'd6, 64'h5_0000_0005, 64'h6_0000_0006, 2'd3, 2'd0);
        exp_cmd.push_back({1'b0, 12'h0A8, 32'd0});
        last_poll = -1;
        drive_start(32'd9, 32'd8, 32'd7, 32'd6, 64'h5_0000_0005, 64'h6_0000_0006, 2'd3, 2'd0);
        for (int unsigned i = 0; i < 200 && exp_cmd.size() > 1; i++) @(negedge clk);
        chk("cfg_done_before_second_start", 64'(exp_cmd.size()), 64'd1);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int unsigned i = 0; i < 200 && !m_pend; i++) @(negedge clk);
        chk("poll_read_outstanding", 64'(m_pend), 64'd1);
        @(negedge clk);
        n0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        chk("cmd_queue_at_reset", 64'(exp_cmd.size()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("late_valid_delivered", 64'(m_pend), 64'd0);
        chk_outputs_zero("after_late_valid");
        chk("no_done_after_reset", 64'(done_cnt), 64'(n0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_tg_cfg_seq.md
# mem_tg_cfg_seq

Hardware sequencer that programs, launches and checks one memory traffic generator (TG) instance through the TG CSR window, with no host software in the loop. It sits between the MEM TG AFU control logic and the TG configuration port, i.e. the window at MEM_TG_CFG_OFFSET 0x1000. Addresses here are relative to that window; the parent adds the offset. On a start pulse it writes a fixed configuration list, writes TG_START, and polls TG_TEST_COMPLETE. It then reads the pass, fail and failure-count results and reports them on status outputs.

## Interface
- POLL_INTERVAL, default 64: idle cycles between TEST_COMPLETE polls (≥1).
- TIMEOUT_CYCLES, default 2^24: cycles allowed from TG_START acceptance to completion.
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle request; accepted only when busy=0.
- cfg_loop_count, cfg_write_count, cfg_read_count, cfg_burst_length  in  32 each  TG count values.
- cfg_wr_start_addr, cfg_rd_start_addr  in  64 each  sequential start addresses.
- cfg_addr_mode_wr, cfg_addr_mode_rd  in  2 each  TG address modes.
- tg_address  out  12  byte address, word aligned.
- tg_write, tg_read  out  1 each  Avalon-MM commands.
- tg_writedata  out  32  write data.
- tg_readdata  in  32  read data.
- tg_readdatavalid  in  1  read response strobe.
- tg_waitrequest  in  1  slave stall.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.
- pass, fail, timeout  out  1 each  sticky result flags, held until the next accepted start.
- fail_count  out  64  TG failure count, held until the next accepted start.

## Operation
- All cfg_* inputs are latched when start is accepted; later changes have no effect on the running sequence.
- States: IDLE → CFG_WR → START_WR → POLL_WAIT → POLL_RD → RES_RD → DONE → IDLE.
- **CFG_WR:** performs 10 writes in this order:
  - LOOP_COUNT 0x008
  - WRITE_COUNT 0x00C
  - READ_COUNT 0x010
  - BURST_LENGTH 0x01C
  - SEQ_START_ADDR_WR_L 0x040
  - SEQ_START_ADDR_WR_H 0x044
  - ADDR_MODE_WR 0x048 (zero-extended)
  - SEQ_START_ADDR_RD_L 0x078
  - SEQ_START_ADDR_RD_H 0x07C
  - ADDR_MODE_RD 0x080 (zero-extended)
  - Index counter 0..9.
- **START_WR:** writes 0x1 to TG_START 0x004. On acceptance, clear the timeout counter and go to POLL_WAIT.
- **POLL_WAIT:** counts POLL_INTERVAL cycles, then goes to POLL_RD.
- **POLL_RD:** reads TG_TEST_COMPLETE 0x0A8.
  - readdata[0]=1 → RES_RD.
  - Otherwise → POLL_WAIT.
- **RES_RD:** four reads in order: TG_PASS 0x088, TG_FAIL 0x08C, FAIL_COUNT_L 0x090, FAIL_COUNT_H 0x094.
  - pass = PASS[0] and fail = FAIL[0].
  - fail_count = {H, L}.
- **Timeout:** the counter is saturating and runs in POLL_WAIT and POLL_RD. When it reaches TIMEOUT_CYCLES:
  - If no read is outstanding, go to DONE immediately.
  - If a read is outstanding, wait for its readdatavalid first, then go to DONE.
  - Set timeout=1; pass=0, fail=0, fail_count=0.
  - A completion seen on that final read is ignored.
- **DONE:** done=1 for one cycle, then IDLE with busy=0.
- start while busy=1 is ignored and neither queued nor counted.
- Async reset mid-sequence: all state, outputs and the latched config clear immediately. No further command is issued, and any outstanding readdatavalid is discarded after reset.

## Timing
- Reset values:
  - tg_address=0, tg_write=0, tg_read=0, tg_writedata=0.
  - busy=0, done=0, pass=0, fail=0, timeout=0, fail_count=0.
- Outputs are registered.
- start accepted at edge N: busy=1 and the first tg_write asserted from N+1.
- Command rule: tg_address, tg_writedata and tg_write/tg_read stay stable while tg_waitrequest=1. A command is accepted on the first edge where the command is high and waitrequest=0.
- At most one read outstanding; no new command is issued until its readdatavalid.
- Back-to-back: with waitrequest=0, the 10 config writes plus the start write take 11 consecutive cycles.
- Read latency is arbitrary (≥1 cycle after acceptance). readdata is sampled only on readdatavalid.
- done pulses in the cycle after the FAIL_COUNT_H data (or timeout exit). busy falls in the same cycle as the done pulse.
- The next start is accepted the cycle after busy falls.

## Test plan
- **Config order:**
  - Stimulus: start with loop=1, wr=16, rd=16, burst=4, wr_addr=0x1_0000_0040, rd_addr=0x40, modes 2/2, waitrequest=0.
  - Required:
    - Writes 0x008=1, 0x00C=0x10, 0x010=0x10, 0x01C=4, 0x040=0x40, 0x044=1, 0x048=2, 0x078=0x40, 0x07C=0, 0x080=2, 0x004=1.
    - These occur on 11 consecutive cycles.
- **Pass path:**
  - Stimulus: the model returns TEST_COMPLETE=0 twice then 1; PASS=1, FAIL=0, counts 0.
  - Required: 3 polls spaced ≥POLL_INTERVAL cycles apart; pass=1, fail=0, fail_count=0; one done pulse.
- **Fail path:**
  - Stimulus: the model returns PASS=0, FAIL=1, FAIL_COUNT_L=0x5, FAIL_COUNT_H=0x2.
  - Required: fail=1, fail_count=0x0000_0002_0000_0005.
- **Waitrequest/latency:**
  - Stimulus: random waitrequest stalls of 0–5 cycles and readdatavalid latency of 1–8 cycles.
  - Required: commands are held stable while stalled, never more than one read is outstanding, and the results match the no-stall run.
- **Timeout:**
  - Stimulus: TIMEOUT_CYCLES=200 and TEST_COMPLETE never set.
  - Required: timeout=1, pass=0, done pulse, busy=0, no result reads issued.
- **Reset/start-while-busy:**
  - Stimulus: start during POLL_WAIT, then rst_n low during POLL_RD.
  - Required: the second start is ignored; all outputs return to 0 immediately; a late readdatavalid after reset causes no state change.
